memory_bus_arbiter: RTL and testbench

Parametrised N-port arbiter that shares one external memory bus among several cache/master ports; it is the generalised successor of the fixed two-port I-cache/D-cache request multiplexer in the core top level. It accepts level-held read/write requests from `NUM_PORTS` masters and serialises them onto a single memory bus. Arbitration is selectable: round-robin or fixed priority. A watchdog aborts transactions the memory never answers and flags them to the requester.

---
 rtl/memory_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_memory_bus_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: shares one memory bus among NUM_PORTS masters.
// Round-robin or fixed-priority grant, optional watchdog abort.
module memory_bus_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             port_read_request,
  input  logic [NUM_PORTS-1:0]             port_write_request,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_write_data,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  port_read_data,
  output logic [NUM_PORTS-1:0]             port_response,
  output logic [NUM_PORTS-1:0]             port_error,
  output logic                             memory_read_request,
  output logic                             memory_write_request,
  output logic [ADDR_WIDTH-1:0]            memory_addr,
  output logic [DATA_WIDTH-1:0]            memory_write_data,
  input  logic                             memory_response,
  input  logic [DATA_WIDTH-1:0]            memory_read_data,
  output logic                             grant_valid,
  output logic [$clog2(NUM_PORTS)-1:0]     grant_index
);

  localparam int IW = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RELEASE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_WIDTH-1:0] w_addr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_wdata [NUM_PORTS];
  logic [DATA_WIDTH-1:0] r_rdata [NUM_PORTS];

  logic [NUM_PORTS-1:0] w_pend;
  logic                 w_any;
  logic [IW-1:0]        w_win;
  logic [IW-1:0]        w_idx;
  logic [IW-1:0]        r_last;
  logic [31:0]          r_cnt;
  logic [31:0]          w_cnt_nxt;
  logic                 w_abort;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign w_addr[i]  = port_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata[i] = port_write_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign port_read_data[i*DATA_WIDTH +: DATA_WIDTH] = r_rdata[i];
  end

  assign w_pend    = port_read_request | port_write_request;
  assign w_any     = |w_pend;
  assign w_cnt_nxt = r_cnt + 32'd1;
  assign w_abort   = (TIMEOUT_CYCLES != 0) && !memory_response &&
                     (w_cnt_nxt == 32'(TIMEOUT_CYCLES));

  // Scan from the far end so the nearest pending port is assigned last.
  always_comb begin
    w_win = '0;
    w_idx = '0;
    if (PRIORITY_MODE != 0) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        w_idx = IW'(i);
        if (w_pend[w_idx]) w_win = w_idx;
      end
    end else begin
      for (int k = NUM_PORTS; k >= 1; k--) begin
        w_idx = IW'((int'(r_last) + k) % NUM_PORTS);
        if (w_pend[w_idx]) w_win = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (w_any) w_state_nxt = S_ACCESS;
      S_ACCESS:  if (memory_response || w_abort) w_state_nxt = S_RELEASE;
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) r_rdata[i] <= '0;
      port_response        <= '0;
      port_error           <= '0;
      memory_read_request  <= 1'b0;
      memory_write_request <= 1'b0;
      memory_addr          <= '0;
      memory_write_data    <= '0;
      grant_valid          <= 1'b0;
      grant_index          <= '0;
      r_last               <= IW'(NUM_PORTS - 1);
      r_cnt                <= '0;
    end else begin
      port_response <= '0;
      port_error    <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            grant_index          <= w_win;
            r_last               <= w_win;
            memory_addr          <= w_addr[w_win];
            memory_write_data    <= w_wdata[w_win];
            memory_write_request <= port_write_request[w_win];
            memory_read_request  <= !port_write_request[w_win];
            grant_valid          <= 1'b1;
            r_cnt                <= '0;
          end
        end
        S_ACCESS: begin
          r_cnt <= w_cnt_nxt;
          if (memory_response || w_abort) begin
            memory_read_request        <= 1'b0;
            memory_write_request       <= 1'b0;
            grant_valid                <= 1'b0;
            port_response[grant_index] <= 1'b1;
            // A real response wins over a watchdog hit in the same cycle.
            if (memory_response) begin
              if (!memory_write_request)
                r_rdata[grant_index] <= memory_read_data;
            end else begin
              r_rdata[grant_index]    <= '0;
              port_error[grant_index] <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb_memory_bus_arbiter: random and directed checks of memory_bus_arbiter
// against a transaction-level reference model.
module tb_memory_bus_arbiter;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;

  logic [3:0]   rdq  [2];
  logic [3:0]   wrq  [2];
  logic [127:0] pa   [2];
  logic [127:0] pwd  [2];
  logic [127:0] prd  [2];
  logic [3:0]   prsp [2];
  logic [3:0]   perr [2];
  logic         mrr  [2];
  logic         mwr  [2];
  logic [31:0]  ma   [2];
  logic [31:0]  mwd  [2];
  logic         mresp[2];
  logic [31:0]  mrd  [2];
  logic         gv   [2];
  logic [1:0]   gi   [2];

  int          n_tot = 0;
  int          n_bad = 0;
  int          last [2];
  int          last_g;
  logic [31:0] m_rd [2][4];

  always #5 clk = ~clk;

  memory_bus_arbiter #(
    .NUM_PORTS(4), .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .PRIORITY_MODE(0), .TIMEOUT_CYCLES(TO)
  ) u_rr (
    .clk(clk), .rst_n(rst_n),
    .port_read_request(rdq[0]), .port_write_request(wrq[0]),
    .port_addr(pa[0]), .port_write_data(pwd[0]),
    .port_read_data(prd[0]), .port_response(prsp[0]),
    .port_error(perr[0]),
    .memory_read_request(mrr[0]), .memory_write_request(mwr[0]),
    .memory_addr(ma[0]), .memory_write_data(mwd[0]),
    .memory_response(mresp[0]), .memory_read_data(mrd[0]),
    .grant_valid(gv[0]), .grant_index(gi[0])
  );

  memory_bus_arbiter #(
    .NUM_PORTS(4), .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .PRIORITY_MODE(1), .TIMEOUT_CYCLES(0)
  ) u_fp (
    .clk(clk), .rst_n(rst_n),
    .port_read_request(rdq[1]), .port_write_request(wrq[1]),
    .port_addr(pa[1]), .port_write_data(pwd[1]),
    .port_read_data(prd[1]), .port_response(prsp[1]),
    .port_error(perr[1]),
    .memory_read_request(mrr[1]), .memory_write_request(mwr[1]),
    .memory_addr(ma[1]), .memory_write_data(mwd[1]),
    .memory_response(mresp[1]), .memory_read_data(mrd[1]),
    .grant_valid(gv[1]), .grant_index(gi[1])
  );

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Unit 1 is fixed priority; unit 0 rotates starting after the last grant.
  function automatic int pick(int u, logic [3:0] pend);
    int c;
    if (u == 1) begin
      c = 0;
      while (c < 4 && !pend[c]) c++;
      return (c < 4) ? c : -1;
    end
    c = last[u] + 1;
    repeat (4) begin
      if (pend[c % 4]) return c % 4;
      c++;
    end
    return -1;
  endfunction

  function automatic logic [127:0] pk(int u);
    logic [127:0] v;
    for (int p = 0; p < 4; p++) v[p*32 +: 32] = m_rd[u][p];
    return v;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      last[u] = 3;
      for (int p = 0; p < 4; p++) m_rd[u][p] = '0;
    end
  endtask

  task automatic raise(int u, int p, bit rd, bit wr,
                       logic [31:0] a, logic [31:0] d);
    rdq[u][p] = rd;
    wrq[u][p] = wr;
    pa[u][p*32 +: 32]  = a;
    pwd[u][p*32 +: 32] = d;
  endtask

  task automatic clear_all(int u);
    rdq[u] = '0;
    wrq[u] = '0;
  endtask

  task automatic chk_reset(int u);
    chk("rst_rdata", prd[u], '0);
    chk("rst_rsp", {prsp[u], perr[u]}, '0);
    chk("rst_req", {mrr[u], mwr[u]}, '0);
    chk("rst_addr", {ma[u], mwd[u]}, '0);
    chk("rst_gnt", {gv[u], gi[u]}, '0);
  endtask

  // Called at an IDLE negedge; returns at the following IDLE negedge.
  // dly = ACCESS cycle (1-based) in which memory answers, 0 = never.
  task automatic txn(int u, int dly, logic [31:0] rdat);
    int          g;
    bit          wr_op;
    bit          done;
    bit          aborted;
    logic [31:0] ea;
    logic [31:0] ed;
    g = pick(u, rdq[u] | wrq[u]);
    if (g < 0) return;
    wr_op = wrq[u][g];
    ea    = pa[u][g*32 +: 32];
    ed    = pwd[u][g*32 +: 32];
    @(posedge clk);
    @(negedge clk);
    last[u] = g;
    last_g  = g;
    chk("gnt_valid", gv[u], 1'b1);
    chk("gnt_idx", gi[u], g);
    chk("op", {mrr[u], mwr[u]}, {!wr_op, wr_op});
    chk("addr", ma[u], ea);
    if (wr_op) chk("wdata", mwd[u], ed);
    pa[u][g*32 +: 32]  = $urandom;
    pwd[u][g*32 +: 32] = $urandom;
    if ($urandom_range(0, 3) == 0) begin
      rdq[u][g] = 1'b0;
      wrq[u][g] = 1'b0;
    end
    done    = 1'b0;
    aborted = 1'b0;
    for (int k = 1; k <= 20 && !done; k++) begin
      chk("req_held", {mrr[u], mwr[u]}, {!wr_op, wr_op});
      chk("addr_hold", ma[u], ea);
      if (k == dly) begin
        mresp[u] = 1'b1;
        mrd[u]   = rdat;
        done     = 1'b1;
      end else if (dly == 0 && u == 0 && k == TO) begin
        done    = 1'b1;
        aborted = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      mresp[u] = 1'b0;
      mrd[u]   = $urandom;
    end
    chk("txn_done", done, 1'b1);
    if (aborted)     m_rd[u][g] = '0;
    else if (!wr_op) m_rd[u][g] = rdat;
    chk("rsp", prsp[u], 4'b1 << g);
    chk("err", perr[u], aborted ? (4'b1 << g) : 4'b0);
    chk("req_low", {mrr[u], mwr[u]}, 2'b00);
    chk("gv_low", gv[u], 1'b0);
    chk("rdata", prd[u], pk(u));
    mresp[u]  = 1'b1;
    mrd[u]    = $urandom;
    rdq[u][g] = 1'b0;
    wrq[u][g] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mresp[u] = 1'b0;
    chk("rsp_pulse", {prsp[u], perr[u]}, '0);
    chk("rdata_keep", prd[u], pk(u));
    chk("idle", gv[u], 1'b0);
  endtask

  task automatic rand_round(int u);
    int r;
    int dly;
    for (int p = 0; p < 4; p++) begin
      if (!(rdq[u][p] | wrq[u][p]) && $urandom_range(0, 1) == 1) begin
        r = $urandom_range(0, 2);
        raise(u, p, r != 1, r != 0, $urandom, $urandom);
      end
    end
    if ((rdq[u] | wrq[u]) == 4'b0)
      raise(u, $urandom_range(0, 3), 1'b1, 1'b0, $urandom, $urandom);
    r   = $urandom_range(0, 9);
    dly = $urandom_range(1, 4);
    if (u == 0 && r == 0) dly = 0;
    if (u == 0 && r == 1) dly = TO;
    txn(u, dly, $urandom);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish t=%0t", $time);
    $fatal(1, "bench watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      rdq[u] = '0; wrq[u] = '0; pa[u] = '0; pwd[u] = '0;
      mresp[u] = 1'b0; mrd[u] = '0;
    end
    model_reset();
    last_g = -1;
    repeat (3) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int p = 0; p < 4; p++) raise(0, p, 1'b1, 1'b0, $urandom, $urandom);
    for (int i = 0; i < 5; i++) begin
      txn(0, 1, $urandom);
      chk("rr_order", last_g, i % 4);
      raise(0, i % 4, 1'b1, 1'b0, $urandom, $urandom);
    end
    clear_all(0);

    raise(0, 2, 1'b1, 1'b0, 32'h100, 32'h0);
    txn(0, 3, 32'hCAFEF00D);
    chk("single_gnt", last_g, 2);
    chk("single_data", prd[0][95:64], 32'hCAFEF00D);

    raise(0, 0, 1'b1, 1'b1, 32'h20, 32'h12345678);
    txn(0, 2, $urandom);
    chk("wr_gnt", last_g, 0);

    raise(0, 1, 1'b1, 1'b0, $urandom, $urandom);
    txn(0, 0, 32'hFFFF_FFFF);
    chk("to_slot", prd[0][63:32], 32'h0);

    raise(0, 3, 1'b1, 1'b0, $urandom, $urandom);
    txn(0, TO, 32'hA5A5_5A5A);
    chk("edge_slot", prd[0][127:96], 32'hA5A5_5A5A);

    raise(0, 2, 1'b1, 1'b0, 32'h200, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rm_access", gv[0], 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset(0);
    rst_n = 1'b1;
    clear_all(0);
    model_reset();
    mresp[0] = 1'b1;
    mrd[0]   = $urandom;
    @(posedge clk);
    @(negedge clk);
    mresp[0] = 1'b0;
    chk("rm_idle", {gv[0], mrr[0], mwr[0]}, '0);
    @(posedge clk);
    @(negedge clk);
    chk("rm_norsp", prsp[0], 4'b0);
    raise(0, 2, 1'b1, 1'b0, $urandom, $urandom);
    raise(0, 0, 1'b1, 1'b0, $urandom, $urandom);
    txn(0, 2, $urandom);
    chk("rm_first", last_g, 0);
    clear_all(0);

    raise(1, 1, 1'b1, 1'b0, $urandom, $urandom);
    raise(1, 3, 1'b1, 1'b0, $urandom, $urandom);
    txn(1, 1, $urandom);
    chk("fp_1a", last_g, 1);
    raise(1, 1, 1'b1, 1'b0, $urandom, $urandom);
    txn(1, 2, $urandom);
    chk("fp_1b", last_g, 1);
    txn(1, 1, $urandom);
    chk("fp_3", last_g, 3);
    clear_all(1);

    for (int it = 0; it < 150; it++) rand_round(0);
    for (int it = 0; it < 60; it++) rand_round(1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
